fp_norm_pipe: RTL

Parametrised, two-stage pipelined normaliser for the floating-point add path of the systolic-array MAC. It left-shifts an unsigned fraction until its MSB is '1', reports the shift amount, and adjusts the exponent. When the normalised exponent would fall below 1, it clamps the shift so the result becomes a subnormal. A valid/ready handshake with full backpressure and a pass-through tag let it sit between the alignment adder and the rounding stage.

---
 rtl/fp_norm_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fp_norm_pipe.sv
`timescale 1ns/1ps
// fp_norm_pipe: two-stage pipelined fraction normaliser with subnormal clamping.
// S1 registers the beat and its leading-zero count.
// S2 applies the shift, adjusts the exponent and holds the results.
// Valid/ready handshake with full backpressure.
module fp_norm_pipe #(
    parameter int WIDTH        = 13,
    parameter int EXP_W        = 5,
    parameter int TAG_W        = 4,
    parameter int DENORM_CLAMP = 1,
    localparam int SHIFT_W     = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_fraction,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_fraction,
    output logic [SHIFT_W-1:0] out_shift,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_zero,
    output logic               out_denorm,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int CMP_W = (SHIFT_W > EXP_W) ? SHIFT_W : EXP_W;

    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_frac;
    logic [EXP_W-1:0]   r_s1_exp;
    logic [TAG_W-1:0]   r_s1_tag;
    logic [SHIFT_W-1:0] r_s1_lzc;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_fraction;
    logic [SHIFT_W-1:0] r_out_shift;
    logic [EXP_W-1:0]   r_out_exp;
    logic               r_out_zero;
    logic               r_out_denorm;
    logic [TAG_W-1:0]   r_out_tag;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic [SHIFT_W-1:0] w_lzc;
    logic               w_found;
    logic               w_zero;
    logic [SHIFT_W-1:0] w_shift;
    logic [EXP_W-1:0]   w_exp;
    logic               w_denorm;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign out_valid    = r_out_valid;
    assign out_fraction = r_out_fraction;
    assign out_shift    = r_out_shift;
    assign out_exp      = r_out_exp;
    assign out_zero     = r_out_zero;
    assign out_denorm   = r_out_denorm;
    assign out_tag      = r_out_tag;

    // Leading-zero count of the incoming fraction; WIDTH when it is all zeros.
    always_comb begin
        w_lzc   = SHIFT_W'(WIDTH);
        w_found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!w_found && in_fraction[WIDTH-1-i]) begin
                w_lzc   = SHIFT_W'(i);
                w_found = 1'b1;
            end
        end
    end

    // Choose the applied shift and resulting exponent, clamping into the subnormal range.
    always_comb begin
        w_zero   = (r_s1_frac == '0);
        w_shift  = r_s1_lzc;
        w_exp    = r_s1_exp - EXP_W'(r_s1_lzc);
        w_denorm = 1'b0;
        if (w_zero) begin
            w_shift = '0;
            w_exp   = '0;
        end else if (DENORM_CLAMP != 0) begin
            if (r_s1_exp == '0) begin
                w_shift  = '0;
                w_exp    = '0;
                w_denorm = 1'b1;
            end else if (CMP_W'(r_s1_lzc) >= CMP_W'(r_s1_exp)) begin
                // lzc >= exp here, so exp-1 always fits in SHIFT_W
                w_shift  = SHIFT_W'(r_s1_exp - EXP_W'(1));
                w_exp    = '0;
                w_denorm = 1'b1;
            end
        end
    end

    // Stage 1: capture the accepted beat and its leading-zero count.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_s1_valid <= 1'b0;
            r_s1_frac  <= '0;
            r_s1_exp   <= '0;
            r_s1_tag   <= '0;
            r_s1_lzc   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_frac <= in_fraction;
                r_s1_exp  <= in_exp;
                r_s1_tag  <= in_tag;
                r_s1_lzc  <= w_lzc;
            end
        end
    end

    // Stage 2: register the normalised result; holds while downstream stalls.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_out_valid    <= 1'b0;
            r_out_fraction <= '0;
            r_out_shift    <= '0;
            r_out_exp      <= '0;
            r_out_zero     <= 1'b0;
            r_out_denorm   <= 1'b0;
            r_out_tag      <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_fraction <= r_s1_frac << w_shift;
                r_out_shift    <= w_shift;
                r_out_exp      <= w_exp;
                r_out_zero     <= w_zero;
                r_out_denorm   <= w_denorm;
                r_out_tag      <= r_s1_tag;
            end
        end
    end

endmodule
